usb_upload_arbiter: RTL and testbench
=====================================

USB_UPLOAD_ARBITER -- requirements
Module: usb_upload_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of upload channels (legal range 1..8).
REQ-002 SHALL have parameter FIFO_AW, default 6, per-channel FIFO address width; depth is 2**FIFO_AW.
REQ-003 SHALL have parameter MAX_BURST, default 64, maximum payload bytes per frame (legal range 1..2**FIFO_AW).
REQ-004 SHALL have parameter FRAME_EN, default 1; 1 means each burst gets a header, 0 means raw payload only.
REQ-005 SHALL have port i_clk, input, 1 bit, sole clock (PHY_CLKOUT domain, 60 MHz).
REQ-006 SHALL have port i_rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-007 SHALL have port i_ch_data, input, NUM_CH*8 bits; channel k uses bits [8k+7:8k].
REQ-008 SHALL have port i_ch_valid, input, NUM_CH bits, per-channel write strobe.
REQ-009 SHALL have port o_ch_ready, output, NUM_CH bits; high means the channel FIFO is not full.
REQ-010 SHALL have port o_ch_ovf, output, NUM_CH bits, sticky overflow flag per channel.
REQ-011 SHALL have port i_ovf_clr, input, 1 bit; clears all o_ch_ovf bits.
REQ-012 SHALL have port o_tx_data, output, 8 bits, merged stream to the endpoint-2 upload input.
REQ-013 SHALL have port o_tx_valid, output, 1 bit, qualifies o_tx_data.
REQ-014 SHALL have port i_tx_ready, input, 1 bit, sink backpressure.
REQ-015 SHALL have port o_busy, output, 1 bit; high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL write a channel byte into its FIFO on i_ch_valid[k]&o_ch_ready[k]. On i_ch_valid[k] while full, it SHALL drop the byte and set o_ch_ovf[k].
REQ-017 SHALL give set priority over i_ovf_clr when an overflow and i_ovf_clr coincide.
REQ-018 SHALL transfer an output byte only on o_tx_valid&i_tx_ready. o_tx_data and o_tx_valid SHALL stay stable while o_tx_valid=1 and i_tx_ready=0.
REQ-019 SHALL implement FSM states IDLE, GRANT, HDR, PAYLOAD.
- IDLE->GRANT when any FIFO is non-empty.
- GRANT->HDR when FRAME_EN=1, otherwise GRANT->PAYLOAD.
- HDR->PAYLOAD after the 4th header byte transfers.
- PAYLOAD->IDLE after the last burst byte transfers.
REQ-020 SHALL select the channel in GRANT round-robin: search starts at last_grant+1 mod NUM_CH, lowest index wins after the wrap, and last_grant resets to NUM_CH-1.
REQ-021 SHALL latch burst length in GRANT as min(count[grant], MAX_BURST), width FIFO_AW+1. Bytes written during the burst SHALL NOT extend it.
REQ-022 SHALL emit the header in order: 0xA5, {5'b0, channel id}, len[7:0], len[15:8] (zero-extended).
REQ-023 SHALL pop exactly one byte from the granted FIFO per accepted payload byte. The FIFO SHALL be first-word-fall-through, so there are no bubbles while i_tx_ready=1.
REQ-024 SHALL present the first output byte with o_tx_valid=1 two cycles after the write of the first byte into an empty, idle block.
REQ-025 SHALL, with i_tx_ready held at 1, sustain 1 byte/cycle within a frame and insert exactly 2 idle cycles between frames (IDLE, GRANT).
REQ-026 SHALL behave correctly on a simultaneous write and pop of the same FIFO: count unchanged, no loss. A full FIFO that pops in the same cycle SHALL accept the write (o_ch_ready includes the pop).
REQ-027 SHALL wrap FIFO pointers modulo 2**FIFO_AW and compute count from FIFO_AW+1-bit pointers.

Reset
REQ-028 SHALL, on i_rst_n=0, asynchronously:
- set FSM to IDLE;
- empty all FIFOs;
- set o_tx_valid=0, o_tx_data=0, o_busy=0, o_ch_ovf=0, o_ch_ready=all ones, last_grant=NUM_CH-1.
REQ-029 SHALL, on reset asserted mid-frame, abandon the frame with no further bytes. After release, the next output SHALL start with a fresh header.

Structure
REQ-030 SHALL place in shared package usb_upload_pkg:
- constant HDR_SYNC=8'hA5;
- FSM state encoding;
- header byte-index constants.
REQ-031 SHALL instantiate one sub-module, upload_ch_fifo (sync FWFT FIFO with count/full/empty), once per channel via generate.

Verification
REQ-032 SHALL be verified with NUM_CH=2: write 3 bytes 0x11,0x22,0x33 to ch0 with ready=1 -> output A5,00,03,00,11,22,33, first byte 2 cycles after the first write.
REQ-033 SHALL be verified with ch0 and ch1 each holding 2 bytes -> ch0 frame then ch1 frame; a further ch0 byte written during the ch1 frame -> ch0 granted next.
REQ-034 SHALL be verified with MAX_BURST=4 and 10 bytes in ch1 -> frames of len 4, 4, 2 in order; payload matches the input sequence.
REQ-035 SHALL be verified by filling ch0 (64 bytes, tx_ready=0) and writing one more -> o_ch_ovf[0]=1 and the byte dropped. Releasing ready -> 64 bytes over 16 frames of len 4 (MAX_BURST=4); i_ovf_clr -> flag 0.
REQ-036 SHALL be verified by toggling i_tx_ready randomly (50%) over 1000 bytes on 4 channels -> stream matches per-channel order, with no duplicates and no loss.
REQ-037 SHALL be verified by asserting i_rst_n=0 mid-payload -> o_tx_valid=0 immediately; after release plus a new write -> output begins with 0xA5.

Source files
------------

// File: rtl/usb_upload_pkg.sv
// usb_upload_pkg: shared constants and FSM encoding for the endpoint-2 upload arbiter
package usb_upload_pkg;
  localparam logic [7:0] HDR_SYNC = 8'hA5;
  typedef enum logic [1:0] {IDLE, GRANT, HDR, PAYLOAD} state_t;
  localparam logic [1:0] HDR_IDX_SYNC   = 2'd0;
  localparam logic [1:0] HDR_IDX_CH     = 2'd1;
  localparam logic [1:0] HDR_IDX_LEN_LO = 2'd2;
  localparam logic [1:0] HDR_IDX_LEN_HI = 2'd3;
endpackage

// File: rtl/upload_ch_fifo.sv
// upload_ch_fifo: first-word-fall-through byte FIFO for one upload channel.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_wr_data/i_wr_en push;
// i_rd_en pop (head is always visible on o_rd_data); o_count occupancy;
// o_full/o_empty status; o_ready accepts a write, including when full but popping.
module upload_ch_fifo #(
  parameter int AW = 6
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [7:0]    i_wr_data,
  input  logic          i_wr_en,
  input  logic          i_rd_en,
  output logic [7:0]    o_rd_data,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_ready
);
  logic [7:0] mem [2**AW];
  logic [AW:0] wr_ptr, rd_ptr;
  logic wr, rd;
  // Pointers carry one extra bit so full and empty are distinguishable.
  assign o_count = wr_ptr - rd_ptr;
  assign o_full = o_count[AW];
  assign o_empty = wr_ptr == rd_ptr;
  assign rd = i_rd_en && !o_empty;
  assign o_ready = !o_full || rd;
  assign wr = i_wr_en && o_ready;
  assign o_rd_data = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + {{AW{1'b0}}, wr};
      rd_ptr <= rd_ptr + {{AW{1'b0}}, rd};
    end
  always_ff @(posedge i_clk)
    if (wr) mem[wr_ptr[AW-1:0]] <= i_wr_data;
endmodule

// File: rtl/usb_upload_arbiter.sv
// usb_upload_arbiter: merges NUM_CH byte channels into one framed upload stream.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_ch_data/i_ch_valid
// per-channel write (o_ch_ready not-full, o_ch_ovf sticky drop flag, i_ovf_clr
// clears it); o_tx_data/o_tx_valid/i_tx_ready merged stream; o_busy FSM not idle.
module usb_upload_arbiter
  import usb_upload_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int FIFO_AW   = 6,
  parameter int MAX_BURST = 64,
  parameter int FRAME_EN  = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_CH*8-1:0] i_ch_data,
  input  logic [NUM_CH-1:0]   i_ch_valid,
  output logic [NUM_CH-1:0]   o_ch_ready,
  output logic [NUM_CH-1:0]   o_ch_ovf,
  input  logic                i_ovf_clr,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_ready,
  output logic                o_busy
);
  localparam int LW = FIFO_AW + 1;
  localparam logic [LW-1:0] MB = LW'(MAX_BURST);
  state_t state, state_n;
  logic [2:0] last_grant, nxt;
  logic [LW-1:0] rem, lvl, blen;
  logic [1:0] hdr_idx;
  logic [NUM_CH-1:0] empty, full, pop;
  logic [7:0] rd_data [NUM_CH];
  logic [LW-1:0] cnt [NUM_CH];
  logic [7:0] pay_data, hdr_byte;
  logic [15:0] len16;
  logic xfer, found;
  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign pop[k] = state == PAYLOAD && i_tx_ready && last_grant == 3'(k);
      upload_ch_fifo #(.AW(FIFO_AW)) u_fifo (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_wr_data(i_ch_data[8*k +: 8]),
        .i_wr_en  (i_ch_valid[k]),
        .i_rd_en  (pop[k]),
        .o_rd_data(rd_data[k]),
        .o_count  (cnt[k]),
        .o_full   (full[k]),
        .o_empty  (empty[k]),
        .o_ready  (o_ch_ready[k])
      );
    end
  endgenerate
  // Round-robin: channels above last_grant first, then wrap to the lowest index.
  // The burst length includes a write landing in the GRANT cycle itself; nothing
  // pops during GRANT, so that write is accepted exactly when the FIFO is not full.
  always_comb begin
    found = 1'b0;
    nxt = last_grant;
    lvl = '0;
    pay_data = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (!found && !empty[k] && 3'(k) > last_grant) begin
        found = 1'b1;
        nxt = 3'(k);
      end
    for (int k = 0; k < NUM_CH; k++)
      if (!found && !empty[k]) begin
        found = 1'b1;
        nxt = 3'(k);
      end
    for (int k = 0; k < NUM_CH; k++) begin
      if (nxt == 3'(k)) lvl = cnt[k] + {{FIFO_AW{1'b0}}, i_ch_valid[k] && !full[k]};
      if (last_grant == 3'(k)) pay_data = rd_data[k];
    end
  end
  assign blen = lvl > MB ? MB : lvl;
  assign xfer = o_tx_valid && i_tx_ready;
  // rem is untouched during HDR, so it still holds the full burst length there.
  assign len16 = 16'(rem);
  assign hdr_byte = hdr_idx == HDR_IDX_SYNC   ? HDR_SYNC :
                    hdr_idx == HDR_IDX_CH     ? {5'b0, last_grant} :
                    hdr_idx == HDR_IDX_LEN_LO ? len16[7:0] : len16[15:8];
  assign o_tx_valid = state == HDR || state == PAYLOAD;
  assign o_tx_data = state == PAYLOAD ? pay_data : state == HDR ? hdr_byte : 8'h00;
  assign o_busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = |(~empty) ? GRANT : IDLE;
      GRANT:   state_n = FRAME_EN != 0 ? HDR : PAYLOAD;
      HDR:     state_n = xfer && hdr_idx == HDR_IDX_LEN_HI ? PAYLOAD : HDR;
      PAYLOAD: state_n = xfer && rem == LW'(1) ? IDLE : PAYLOAD;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      last_grant <= 3'(NUM_CH - 1);
      rem <= '0;
      hdr_idx <= HDR_IDX_SYNC;
      o_ch_ovf <= '0;
    end else begin
      state <= state_n;
      o_ch_ovf <= (i_ch_valid & ~o_ch_ready) | (i_ovf_clr ? '0 : o_ch_ovf);
      if (state == GRANT) begin
        last_grant <= nxt;
        rem <= blen;
        hdr_idx <= HDR_IDX_SYNC;
      end
      if (state == HDR && xfer) hdr_idx <= hdr_idx + 2'd1;
      if (state == PAYLOAD && xfer) rem <= rem - LW'(1);
    end
endmodule

// File: tb/tb_usb_upload_arbiter.sv
// tb_usb_upload_arbiter: directed and randomized checks of the framed upload stream
module tb_usb_upload_arbiter;
  localparam int N = 4;
  localparam int MB = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ovf_clr = 1'b0;
  logic tx_ready = 1'b0;
  logic [N*8-1:0] ch_data = '0;
  logic [N-1:0] ch_valid = '0;
  logic [N-1:0] ch_ready, ch_ovf;
  logic [7:0] tx_data;
  logic tx_valid, busy;
  int chk = 0;
  int errs = 0;
  int cyc = 0;
  logic [7:0] mq [N][$];
  logic [7:0] outq[$];
  logic [7:0] expq[$];
  int outc[$];

  always #5 clk = ~clk;

  usb_upload_arbiter #(.NUM_CH(N), .FIFO_AW(6), .MAX_BURST(MB), .FRAME_EN(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ch_data(ch_data), .i_ch_valid(ch_valid),
    .o_ch_ready(ch_ready), .o_ch_ovf(ch_ovf), .i_ovf_clr(ovf_clr),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .o_busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int k, input logic [7:0] d);
    ch_valid[k] = 1'b1;
    ch_data[8*k +: 8] = d;
  endtask

  // One clock: record accepted writes into the per-channel model and transfers
  // into the observed stream, just before the edge that commits them.
  task automatic tick();
    #1;
    for (int k = 0; k < N; k++)
      if (ch_valid[k] && ch_ready[k]) mq[k].push_back(ch_data[8*k +: 8]);
    if (tx_valid && tx_ready) begin
      outq.push_back(tx_data);
      outc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    ch_valid = '0;
    ovf_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tx_ready = 1'b0;
    ch_valid = '0;
    ovf_clr = 1'b0;
    for (int k = 0; k < N; k++) mq[k].delete();
    outq.delete();
    outc.delete();
    expq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Expected frame for channel k: header then min(queued, MB) bytes in write order.
  task automatic exp_frame(input int k);
    int n;
    n = mq[k].size() < MB ? mq[k].size() : MB;
    expq.push_back(8'hA5);
    expq.push_back(8'(k));
    expq.push_back(8'(n));
    expq.push_back(8'(n >> 8));
    repeat (n) expq.push_back(mq[k].pop_front());
  endtask

  task automatic run_until(input int n);
    int b;
    b = 0;
    while (outq.size() < n && b < 3000) begin
      tick();
      b++;
    end
    check("stream_timeout", 32'(outq.size() >= n), 1);
  endtask

  task automatic cmp_stream(input string tag);
    run_until(expq.size());
    repeat (8) tick();
    check({tag, "_len"}, outq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < outq.size(); i++) check(tag, outq[i], expq[i]);
  endtask

  initial begin
    int total, idle, i, pay, ch, len;
    @(negedge clk);
    check("rst_valid", tx_valid, 0);
    check("rst_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ch_ovf, 0);
    check("rst_ready", ch_ready, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;

    // Single 3-byte frame; first byte two cycles after the first write.
    tx_ready = 1'b1;
    wr(0, 8'h11); tick();
    check("lat_c1", tx_valid, 0);
    wr(0, 8'h22); tick();
    check("lat_c2", tx_valid, 0);
    wr(0, 8'h33); tick();
    check("lat_valid", tx_valid, 1);
    check("lat_data", tx_data, 8'hA5);
    exp_frame(0);
    cmp_stream("basic");
    if (outc.size() >= 7) check("basic_rate", outc[6] - outc[0], 6);

    // Two channels, then a late ch0 byte during the ch1 frame.
    do_reset();
    wr(0, 8'hA1); wr(1, 8'hB1); tick();
    wr(0, 8'hA2); wr(1, 8'hB2); tick();
    exp_frame(0);
    exp_frame(1);
    tx_ready = 1'b1;
    run_until(8);
    wr(0, 8'h77); tick();
    exp_frame(0);
    cmp_stream("rr");
    if (outc.size() >= 7) begin
      check("rr_rate", outc[5] - outc[0], 5);
      check("rr_gap", outc[6] - outc[5], 3);
    end

    // Burst splitting with round-robin between ch1 and ch2.
    do_reset();
    wr(0, 8'hC0); tick();
    repeat (2) tick();
    for (int k = 0; k < 10; k++) begin
      wr(1, 8'(8'h10 + k));
      if (k < 5) wr(2, 8'(8'h20 + k));
      tick();
    end
    exp_frame(0); exp_frame(1); exp_frame(2); exp_frame(1); exp_frame(2); exp_frame(1);
    tx_ready = 1'b1;
    cmp_stream("burst");

    // Overflow: ch1 holds the arbiter while ch0 fills completely.
    do_reset();
    wr(1, 8'h5C); tick();
    repeat (2) tick();
    for (int k = 0; k < 64; k++) begin
      wr(0, 8'(k * 3 + 1));
      tick();
    end
    check("ovf_ready_full", ch_ready[0], 0);
    check("ovf_pre", ch_ovf, 0);
    wr(0, 8'hEE); tick();
    check("ovf_set", ch_ovf, 4'b0001);
    wr(0, 8'hEF); ovf_clr = 1'b1; tick();
    check("ovf_set_prio", ch_ovf, 4'b0001);
    ovf_clr = 1'b1; tick();
    check("ovf_clr", ch_ovf, 0);
    exp_frame(1);
    repeat (16) exp_frame(0);
    tx_ready = 1'b1;
    cmp_stream("ovf_drain");

    // Reset in the middle of a payload.
    do_reset();
    tx_ready = 1'b1;
    wr(0, 8'h61); tick();
    wr(0, 8'h62); tick();
    wr(0, 8'h63); tick();
    run_until(5);
    check("mid_valid", tx_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", tx_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", tx_data, 0);
    check("mid_rst_ready", ch_ready, 4'hF);
    do_reset();
    tx_ready = 1'b1;
    wr(1, 8'h5A); tick();
    exp_frame(1);
    cmp_stream("rst_fresh");

    // Random traffic on four channels with random backpressure.
    do_reset();
    total = 0;
    idle = 0;
    for (int c = 0; c < 40000 && !(total == 1000 && idle >= 3); c++) begin
      tx_ready = 1'($urandom_range(0, 1));
      #1;
      for (int k = 0; k < N; k++)
        if (total < 1000 && ch_ready[k] && $urandom_range(0, 1) == 1) begin
          wr(k, 8'($urandom));
          total++;
        end
      tick();
      idle = busy ? 0 : idle + 1;
    end
    check("rnd_done", 32'(total == 1000 && idle >= 3), 1);
    i = 0;
    pay = 0;
    while (i + 4 <= outq.size()) begin
      check("rnd_sync", outq[i], 8'hA5);
      ch = outq[i+1];
      len = {outq[i+3], outq[i+2]};
      check("rnd_ch", 32'(ch < N), 1);
      check("rnd_len", 32'(len >= 1 && len <= MB), 1);
      i += 4;
      if (ch >= N) break;
      for (int j = 0; j < len && i < outq.size(); j++) begin
        check("rnd_model_nonempty", 32'(mq[ch].size() > 0), 1);
        if (mq[ch].size() > 0) check("rnd_payload", outq[i], mq[ch].pop_front());
        i++;
        pay++;
      end
    end
    check("rnd_tail", i, outq.size());
    check("rnd_total", pay, 1000);
    for (int k = 0; k < N; k++) check("rnd_left", mq[k].size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, chk);
    $finish;
  end
endmodule
